// File: rtl/race_sequencer.sv
// race_sequencer
//   Game-flow controller for the racing game. Owns the update-tick
//   prescaler, obstacle-drop and score timers, lives bookkeeping and the
//   IDLE/PLAY/CRASH/OVER sequencing that drives the road datapath.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   reset        synchronous, active-high reset
//   start        level start request from the board button (edge-detected)
//   colision     collision flag from the road datapath
//   upsig        one-cycle update pulse, registered, PLAY only
//   drop         one-cycle obstacle-drop pulse, PLAY only
//   restart      one-cycle pulse: datapath re-centres car, clears obstacles
//   flash        red overlay enable
//   state        IDLE=00, PLAY=01, CRASH=10, OVER=11
//   lives        remaining lives
//   total_score  score in points, saturates at 63
//   game_over    high exactly while state==OVER
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start edge; last game's score still shown
// PLAY  | game running; timers advance, collision ends the life
// CRASH | flash toggles per tick for CRASH_TICKS ticks, then resume/over
// OVER  | no lives left; overlay held on, score frozen until start edge

module race_sequencer #(
  parameter int TICK_DIV    = 131072,
  parameter int DROP_DIV    = 13282293,
  parameter int SCORE_DIV   = 50000000,
  parameter int CRASH_TICKS = 16,
  parameter int LIVES       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       colision,
  output logic       upsig,
  output logic       drop,
  output logic       restart,
  output logic       flash,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [5:0] total_score,
  output logic       game_over
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DROP_DIV  > 1) ? $clog2(DROP_DIV)  : 1;
  localparam int SW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int CW = $clog2(CRASH_TICKS + 1);

  localparam logic [TW-1:0] TICK_TC   = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DROP_TC   = DW'(DROP_DIV - 1);
  localparam logic [SW-1:0] SCORE_TC  = SW'(SCORE_DIV - 1);
  localparam logic [CW-1:0] CRASH_END = CW'(CRASH_TICKS);
  localparam logic [1:0]    LIVES_INI = 2'(LIVES);
  localparam logic [5:0]    SCORE_MAX = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_CRASH = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] drop_cnt;
  logic          drop_tc;
  logic [SW-1:0] score_cnt;
  logic          score_tc;
  logic [CW-1:0] crash_cnt;
  logic          crash_done;

  logic start_q;
  logic start_armed;
  logic start_edge;

  // FSM strobes, decoded in the next-state process
  logic new_game;
  logic crash_hit;
  logic resume;
  logic go_over;
  logic leave_over;

  assign tick       = (tick_cnt == TICK_TC);
  assign drop_tc    = (drop_cnt == DROP_TC);
  assign score_tc   = (score_cnt == SCORE_TC);
  assign crash_done = (crash_cnt == CRASH_END);

  // start_armed is only set after start has been seen low since reset, so
  // a button held through reset release never reads as a press.
  assign start_edge = start & ~start_q & start_armed;

  assign state     = cur_state;
  assign game_over = (cur_state == S_OVER);
  assign drop      = (cur_state == S_PLAY) && drop_tc;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------
  always_comb begin
    nxt_state  = cur_state;
    new_game   = 1'b0;
    crash_hit  = 1'b0;
    resume     = 1'b0;
    go_over    = 1'b0;
    leave_over = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start_edge) begin
          nxt_state = S_PLAY;
          new_game  = 1'b1;
        end
      end
      S_PLAY: begin
        if (colision) begin
          nxt_state = S_CRASH;
          crash_hit = 1'b1;
        end
      end
      S_CRASH: begin
        // lives was already decremented on entry
        if (crash_done) begin
          if (lives == 2'd0) begin
            nxt_state = S_OVER;
            go_over   = 1'b1;
          end else begin
            nxt_state = S_PLAY;
            resume    = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start_edge) begin
          nxt_state  = S_IDLE;
          leave_over = 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Start edge detector
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q     <= start;
      start_armed <= start_armed | ~start;
    end
  end

  // ---------------------------------------------------------------------
  // Update-tick prescaler, free-running in every state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Registered from the current state: a tick in the last PLAY cycle still
  // yields its pulse on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      upsig <= 1'b0;
    end else begin
      upsig <= tick && (cur_state == S_PLAY);
    end
  end

  // ---------------------------------------------------------------------
  // Obstacle-drop timer: advances in PLAY, holds elsewhere, cleared
  // whenever the road is restarted
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (new_game || resume) begin
      drop_cnt <= '0;
    end else if (cur_state == S_PLAY) begin
      if (drop_tc) begin
        drop_cnt <= '0;
      end else begin
        drop_cnt <= drop_cnt + DW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Score timer and saturating point counter. A point earned in the same
  // cycle as a collision is still awarded.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      score_cnt   <= '0;
      total_score <= '0;
    end else if (new_game) begin
      score_cnt   <= '0;
      total_score <= '0;
    end else if (cur_state == S_PLAY) begin
      if (score_tc) begin
        score_cnt <= '0;
        if (total_score != SCORE_MAX) begin
          total_score <= total_score + 6'd1;
        end
      end else begin
        score_cnt <= score_cnt + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lives
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      lives <= LIVES_INI;
    end else if (new_game) begin
      lives <= LIVES_INI;
    end else if (crash_hit && (lives != 2'd0)) begin
      lives <= lives - 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Crash timer and overlay. The exit is taken the cycle after the final
  // tick, so every one of the CRASH_TICKS toggles is visible.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      crash_cnt <= '0;
    end else if (crash_hit) begin
      crash_cnt <= '0;
    end else if ((cur_state == S_CRASH) && tick && !crash_done) begin
      crash_cnt <= crash_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash <= 1'b0;
    end else if (resume || leave_over) begin
      flash <= 1'b0;
    end else if (go_over) begin
      flash <= 1'b1;
    end else if ((cur_state == S_CRASH) && tick && !crash_done) begin
      flash <= ~flash;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      restart <= 1'b0;
    end else begin
      restart <= new_game || resume;
    end
  end

endmodule
